// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one SDRAM Avalon-MM master among NUM_REQ audio cores.
// Define SDRAM_ARB_FIXED_PRIO_EN to give requester 0 (record) absolute priority over the rest.
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 23,
  parameter int DW      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_writedata,
  output logic [DW-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]    req_finished,
  output logic [NUM_REQ-1:0]    grant,
  output logic [AW-1:0]         avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DW-1:0]         avm_writedata,
  input  logic [DW-1:0]         avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic [1:0]            debug
);

  localparam int LW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_CMD    = 2'b01;
  localparam logic [1:0] S_RDWAIT = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LW-1:0]      last_q, last_d;
  logic               op_wr_q, op_wr_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic [NUM_REQ-1:0] active;
  logic               win_found;
  logic [LW-1:0]      win_idx;

  assign active = req_read | req_write;

  // Winner search starts just after the previous owner so nobody is starved.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    if (active[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        if (!win_found && active[1 + ((int'(last_q) - 1 + k) % (NUM_REQ - 1))]) begin
          win_found = 1'b1;
          win_idx   = LW'(1 + ((int'(last_q) - 1 + k) % (NUM_REQ - 1)));
        end
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && active[(int'(last_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = LW'((int'(last_q) + k) % NUM_REQ);
      end
    end
`endif
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          op_wr_d = req_write[win_idx];
          addr_d  = req_addr[int'(win_idx)*AW +: AW];
          wdata_d = req_writedata[int'(win_idx)*DW +: DW];
`ifdef SDRAM_ARB_FIXED_PRIO_EN
          if (win_idx != '0) last_d = win_idx;
`else
          last_d  = win_idx;
`endif
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!avm_waitrequest) state_d = op_wr_q ? S_DONE : S_RDWAIT;
      end
      S_RDWAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = S_DONE;
        end
      end
      default: begin
        // DONE never arbitrates, so a stale request from the owner cannot be re-granted.
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_REQ - 1);
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign avm_read      = (state_q == S_CMD) && !op_wr_q;
  assign avm_write     = (state_q == S_CMD) &&  op_wr_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign req_readdata  = rdata_q;
  assign req_finished  = (state_q == S_DONE) ? grant_q : '0;
  assign grant         = grant_q;
  assign debug         = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus queues expected completions, a monitor checks them.
module tb_sdram_arbiter;

  localparam int NUM_REQ = 3;
  localparam int AW      = 23;
  localparam int DW      = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_read = '0;
  logic [NUM_REQ-1:0]    req_write = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_writedata = '0;
  logic [DW-1:0]         req_readdata;
  logic [NUM_REQ-1:0]    req_finished;
  logic [NUM_REQ-1:0]    grant;
  logic [AW-1:0]         avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [DW-1:0]         avm_writedata;
  logic [DW-1:0]         avm_readdata = '0;
  logic                  avm_readdatavalid = 1'b0;
  logic                  avm_waitrequest;
  logic [1:0]            debug;

  always #5 clk = ~clk;

  sdram_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_writedata     (req_writedata),
    .req_readdata      (req_readdata),
    .req_finished      (req_finished),
    .grant             (grant),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .debug             (debug)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SDRAM model: stalls stall_cfg cycles per command, returns data rd_lat cycles after acceptance.
  int          stall_cfg = 0;
  int          rd_lat = 1;
  int          stall_cnt = 0;
  int          pend = 0;
  logic [DW-1:0] pend_data = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hDEADBEEF + {9'd0, a} - 32'h100;
  endfunction

  assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < stall_cfg);

  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (!(avm_read || avm_write)) stall_cnt <= 0;
    else if (stall_cnt < stall_cfg) stall_cnt <= stall_cnt + 1;
    if (avm_read && !avm_waitrequest) begin
      if (rd_lat <= 1) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem_word(avm_address);
      end else begin
        pend      <= rd_lat - 1;
        pend_data <= mem_word(avm_address);
      end
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= pend_data;
      end
    end
  end

  typedef struct packed {
    logic [NUM_REQ-1:0] fin;
    logic [DW-1:0]      data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && req_finished != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_finish", DW'(req_finished), '0);
      end else begin
        mon_e = exp_q.pop_front();
        check("finished_vec", DW'(req_finished), DW'(mon_e.fin));
        check("finished_readdata", req_readdata, mon_e.data);
      end
    end
  end

  logic [NUM_REQ-1:0] prev_grant = '0;
  logic [NUM_REQ-1:0] grant_log[$];

  always @(negedge clk) begin
    if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
    prev_grant = grant;
  end

  task automatic push_exp(input logic [NUM_REQ-1:0] fin, input logic [DW-1:0] data);
    exp_t e;
    e.fin  = fin;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[idx*AW +: AW]      = a;
    req_writedata[idx*DW +: DW] = d;
  endtask

  task automatic wait_finish(input int idx, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_finished[idx] && cyc < 50);
    if (!req_finished[idx]) check("finish_timeout", 32'd0, 32'd1);
  endtask

  // Counts completion pulses; at the n-th one, runs until that negedge and returns.
  task automatic wait_n_finishes(input int n, output int got);
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_finished != '0) got++;
    end
    if (got < n) check("finish_count_timeout", DW'(got), DW'(n));
  endtask

  int cyc;
  int got;

  initial begin
    #1;
    check("rst_grant", DW'(grant), '0);
    check("rst_finished", DW'(req_finished), '0);
    check("rst_avm_rw", DW'({avm_read, avm_write}), '0);
    check("rst_avm_addr", DW'(avm_address), '0);
    check("rst_avm_wdata", avm_writedata, '0);
    check("rst_readdata", req_readdata, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_debug", DW'(debug), 32'd0);

    // Single read from requester 1.
    set_req(1, 23'h000100, '0);
    req_read[1] = 1'b1;
    push_exp(3'b010, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_cmd_avm_read", DW'(avm_read), 32'd1);
    check("rd_cmd_avm_write", DW'(avm_write), 32'd0);
    check("rd_cmd_addr", DW'(avm_address), 32'h100);
    check("rd_cmd_debug", DW'(debug), 32'd1);
    check("rd_cmd_grant", DW'(grant), 32'b010);
    @(negedge clk);
    check("rd_wait_avm_read", DW'(avm_read), 32'd0);
    check("rd_wait_debug", DW'(debug), 32'd2);
    @(negedge clk);
    check("rd_done_finished", DW'(req_finished), 32'b010);
    check("rd_done_debug", DW'(debug), 32'd3);
    req_read[1] = 1'b0;
    @(negedge clk);
    check("rd_after_grant", DW'(grant), '0);
    check("rd_after_readdata", req_readdata, 32'hDEADBEEF);

    // Write from requester 0 with three stall cycles.
    stall_cfg = 3;
    set_req(0, 23'h7FFFFF, 32'h12345678);
    req_write[0] = 1'b1;
    push_exp(3'b001, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wr_avm_write", DW'(avm_write), 32'd1);
      check("wr_avm_addr", DW'(avm_address), 32'h7FFFFF);
      check("wr_avm_wdata", avm_writedata, 32'h12345678);
      check("wr_waitreq", DW'(avm_waitrequest), (i < 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("wr_finished", DW'(req_finished), 32'b001);
    check("wr_avm_write_off", DW'(avm_write), 32'd0);
    req_write[0] = 1'b0;
    stall_cfg = 0;
    @(negedge clk);

    // Requester 2 re-targets to A+1 right after finishing at A.
    set_req(2, 23'h000300, '0);
    req_read[2] = 1'b1;
    push_exp(3'b100, 32'hDEADC0EF);
    wait_finish(2, cyc);
    check("retarget_latency", DW'(cyc), 32'd3);
    set_req(2, 23'h000301, '0);
    push_exp(3'b100, 32'hDEADC0F0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!avm_read && cyc < 20);
    check("retarget_cmd_seen", DW'(avm_read), 32'd1);
    check("retarget_addr", DW'(avm_address), 32'h301);
    wait_finish(2, cyc);
    req_read[2] = 1'b0;
    @(negedge clk);

    // Async reset while waiting for read data; the late data must be ignored.
    rd_lat = 4;
    set_req(1, 23'h000100, '0);
    req_read[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (debug != 2'd2 && cyc < 20);
    check("rst_mid_reached_rdwait", DW'(debug), 32'd2);
    rst_n = 1'b0;
    req_read[1] = 1'b0;
    #1;
    check("rst_mid_grant", DW'(grant), '0);
    check("rst_mid_debug", DW'(debug), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid_idle", DW'({debug, grant, req_finished}), '0);
    end
    check("rst_mid_readdata", req_readdata, '0);
    check("rst_mid_avm_addr", DW'(avm_address), '0);
    rd_lat = 1;

    grant_log.delete();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Requester 0 wins every arbitration while active.
    set_req(0, 23'h000200, '0);
    set_req(1, 23'h000201, '0);
    req_read[1:0] = 2'b11;
    for (int i = 0; i < 3; i++) push_exp(3'b001, 32'hDEADBFEF);
    wait_n_finishes(3, got);
    req_read[0] = 1'b0;
    push_exp(3'b010, 32'hDEADBFF0);
    wait_n_finishes(1, got);
    req_read[1] = 1'b0;
    check("prio_grant_count", DW'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("prio_grant_order", DW'(grant_log[i]), (i < 3) ? 32'b001 : 32'b010);
`else
    // All three hold read requests: grants rotate 0,1,2,0,1,2.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'(23'h200 + i), '0);
    req_read = '1;
    for (int i = 0; i < 6; i++)
      push_exp(3'b001 << (i % 3), 32'hDEADBFEF + DW'(i % 3));
    wait_n_finishes(6, got);
    req_read = '0;
    check("rr_grant_count", DW'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("rr_grant_order", DW'(grant_log[i]), 32'b001 << (i % 3));
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion of the test sequence, expected it within 200000 time units");
    $fatal(1);
  end

endmodule
